alu32_issue_ctrl: RTL and testbench
===================================

# alu32_issue_ctrl

Sequential initiator for the `alu32` datapath in the R-type single-cycle MIPS core. It accepts one R-type instruction with its two register operands over a valid/ready handshake, decodes `funct` into the 3-bit ALU select, and drives registered operands into `alu32`. After a configurable settle time it captures `out`/`cout`/`overflow` and returns a writeback response with destination register and write enable.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles the ALU inputs are held before capture. Legal range 1..15.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: block can accept a command.
- `cmd_instr` in 32: R-type instruction word.
- `cmd_rs_data` in 32: value of register rs.
- `cmd_rt_data` in 32: value of register rt.
- `alu_a` out 32: registered ALU operand A.
- `alu_b` out 32: registered ALU operand B.
- `alu_sel` out 3: registered ALU select.
- `alu_out` in 32: ALU result.
- `alu_cout` in 1: ALU carry out.
- `alu_ovf` in 1: ALU signed overflow.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts response.
- `rsp_data` out 32: captured result.
- `rsp_rd` out 5: destination register.
- `rsp_we` out 1: register-file write enable.
- `rsp_cout` out 1: captured carry.
- `rsp_ovf` out 1: captured overflow.
- `rsp_err` out 1: illegal instruction, or trapped overflow.

## Operation
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [5:0]. Opcode must be 0.
- Decode from `funct` to `alu_sel`:
  - 0x24 AND -> 000
  - 0x25 OR -> 001
  - 0x20 ADD -> 010
  - 0x26 XOR -> 011
  - 0x22 SUB -> 100
  - 0x03 SRA -> 101
  - 0x00 SLL -> 110
  - 0x27 NOR -> 111
  - Any other funct, or opcode ≠ 0: illegal.
- Operands:
  - Non-shift: `alu_a` = rs_data, `alu_b` = rt_data.
  - Shift (SLL/SRA): `alu_a` = rt_data, `alu_b` = {27'b0, shamt}.
- State machine has three states:
  - IDLE (`cmd_ready` = 1). On `cmd_valid`: if the command is legal, load `alu_*`, set counter to SETTLE_CYCLES-1, go to WAIT. If illegal, load the response with err=1, we=0, data=0, cout=0, ovf=0, go to RESP.
  - WAIT: if counter = 0, capture the ALU outputs into the `rsp_*` registers and go to RESP. Otherwise decrement the counter.
  - RESP (`rsp_valid` = 1). On `rsp_ready`, go to IDLE.
- `cmd_ready` is high only in IDLE. One command is in flight at a time. Any `cmd_valid` outside IDLE is ignored.
- `rsp_cout`/`rsp_ovf` are captured only for ADD/SUB. For all other operations they are forced to 0.
- `rsp_we` = 1 for legal ops with rd ≠ 0. For rd = 0, `rsp_we` = 0, but data is still reported.
- `rsp_rd` = rd field. On an illegal instruction it is still the rd field.
- `rsp_ready` while `rsp_valid` = 0 has no effect.

## Timing
- Reset (synchronous, `rst_n` = 0 at an edge): state IDLE. All `alu_*` and `rsp_*` outputs are 0, `rsp_valid` = 0. `cmd_ready` = 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset in WAIT or RESP aborts the operation and drops the response.
- Legal command accepted at edge N:
  - `alu_*` valid from N+1.
  - Capture at edge N+SETTLE_CYCLES.
  - `rsp_valid` high from N+SETTLE_CYCLES+1.
- Illegal command accepted at edge N: `rsp_valid` high from N+1.
- All `rsp_*` outputs are stable while `rsp_valid` = 1 and `rsp_ready` = 0.
- `alu_*` outputs hold their value until the next accept.
- Peak throughput: one command per SETTLE_CYCLES+2 cycles (with `rsp_ready` held high).

## Configuration
- `ALU_OVF_TRAP_EN` defined: ADD/SUB with a captured overflow gives `rsp_err` = 1 and `rsp_we` = 0. `rsp_data` still holds the wrapped result.
- Macro undefined: overflow is reported on `rsp_ovf` only. `rsp_err` is set only for illegal instructions, and `rsp_we` follows the rd rule.

## Structure
- Package `rtype_alu_pkg`:
  - ALU select localparams (`SEL_AND`..`SEL_NOR`).
  - funct localparams.
  - State encoding IDLE/WAIT/RESP.
- Sub-module `rtype_funct_decode`: combinational; maps opcode/funct to `sel`, `is_shift`, `is_arith`, `illegal`.
- Top level contains the FSM, settle counter, operand registers and response registers.

## Test plan
- ADD: rs = 0xC00000EA, rt = 0xF1E00000, rd = 8 -> `alu_sel` = 010, `rsp_data` = 0xB1E000EA, cout = 1, ovf = 0, we = 1, `rsp_valid` at accept+2 (SETTLE_CYCLES = 1).
- SUB: rs = 0x7FFFFFFF, rt = 0xFFFFFFFF -> data = 0x80000000, ovf = 1. With `ALU_OVF_TRAP_EN`: err = 1, we = 0. Without it: err = 0, we = 1.
- Shifts with rt = 0xC00000FF, shamt = 3 -> `alu_b` = 3. SRA gives 0xF800001F. SLL gives 0x000007F8. cout = ovf = 0 for both.
- Illegal: funct 0x2A -> err = 1, we = 0, data = 0, `rsp_valid` at accept+1. Opcode 0x08 also gives err = 1.
- Backpressure: hold `rsp_ready` low 5 cycles -> `rsp_*` stable, `cmd_ready` = 0. Second command with `cmd_valid` held high is accepted on the first IDLE cycle after the response handshake.
- Reset mid-WAIT with SETTLE_CYCLES = 4 -> no `rsp_valid`, all outputs 0, `cmd_ready` = 1 in the cycle after release. A rd = 0 AND command then gives we = 0.

Source files
------------

// File: rtl/rtype_alu_pkg.sv
// Shared definitions for the R-type ALU issue controller: ALU select codes,
// R-type funct codes and the controller state encoding.
package rtype_alu_pkg;

    localparam int DATA_W = 32;

    // ALU select codes understood by alu32
    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_XOR = 3'b011;
    localparam logic [2:0] SEL_SUB = 3'b100;
    localparam logic [2:0] SEL_SRA = 3'b101;
    localparam logic [2:0] SEL_SLL = 3'b110;
    localparam logic [2:0] SEL_NOR = 3'b111;

    // R-type funct codes
    localparam logic [5:0] FUNCT_SLL = 6'h00;
    localparam logic [5:0] FUNCT_SRA = 6'h03;
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_XOR = 6'h26;
    localparam logic [5:0] FUNCT_NOR = 6'h27;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/rtype_funct_decode.sv
// Combinational R-type decoder: opcode/funct to ALU select plus class flags.
module rtype_funct_decode
    import rtype_alu_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic [2:0] sel,
    output logic       is_shift,
    output logic       is_arith,
    output logic       illegal
);

    // Map funct to select; anything unknown or a non-zero opcode is illegal
    always_comb begin
        sel      = SEL_AND;
        is_shift = 1'b0;
        is_arith = 1'b0;
        illegal  = 1'b0;
        case (funct)
            FUNCT_AND: sel = SEL_AND;
            FUNCT_OR:  sel = SEL_OR;
            FUNCT_ADD: begin sel = SEL_ADD; is_arith = 1'b1; end
            FUNCT_XOR: sel = SEL_XOR;
            FUNCT_SUB: begin sel = SEL_SUB; is_arith = 1'b1; end
            FUNCT_SRA: begin sel = SEL_SRA; is_shift = 1'b1; end
            FUNCT_SLL: begin sel = SEL_SLL; is_shift = 1'b1; end
            FUNCT_NOR: sel = SEL_NOR;
            default:   illegal = 1'b1;
        endcase
        if (opcode != OPCODE_RTYPE) begin
            illegal = 1'b1;
        end
        if (illegal) begin
            sel      = SEL_AND;
            is_shift = 1'b0;
            is_arith = 1'b0;
        end
    end

endmodule

// File: rtl/alu32_issue_ctrl.sv
// Sequential issue controller for alu32: accepts one R-type command, drives
// registered operands, waits SETTLE_CYCLES, captures the ALU result and
// presents a writeback response.
// Optional build macro ALU_OVF_TRAP_EN: ADD/SUB overflow raises rsp_err and
// suppresses rsp_we (rsp_data still carries the wrapped result).
module alu32_issue_ctrl
    import rtype_alu_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [31:0]       cmd_instr,
    input  logic [31:0]       cmd_rs_data,
    input  logic [31:0]       cmd_rt_data,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_sel,
    input  logic [31:0]       alu_out,
    input  logic              alu_cout,
    input  logic              alu_ovf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_we,
    output logic              rsp_cout,
    output logic              rsp_ovf,
    output logic              rsp_err
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  cnt_q;
    logic [4:0]  rd_q;
    logic        arith_q;

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rd_f;
    logic [4:0]  shamt;
    logic [2:0]  dec_sel;
    logic        dec_shift;
    logic        dec_arith;
    logic        dec_illegal;
    logic        ovf_trap;
    logic        unused_fields;

    assign opcode = cmd_instr[31:26];
    assign rd_f   = cmd_instr[15:11];
    assign shamt  = cmd_instr[10:6];
    assign funct  = cmd_instr[5:0];

    // rs/rt register numbers are resolved upstream; only their data arrives here
    assign unused_fields = ^cmd_instr[25:16];

    rtype_funct_decode u_decode (
        .opcode   (opcode),
        .funct    (funct),
        .sel      (dec_sel),
        .is_shift (dec_shift),
        .is_arith (dec_arith),
        .illegal  (dec_illegal)
    );

`ifdef ALU_OVF_TRAP_EN
    assign ovf_trap = arith_q & alu_ovf;
`else
    assign ovf_trap = 1'b0;
`endif

    // cmd_ready is gated by rst_n so nothing is offered while reset is held
    assign cmd_ready = rst_n && (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = dec_illegal ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand load on accept, settle countdown, and response capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            cnt_q    <= '0;
            rd_q     <= '0;
            arith_q  <= 1'b0;
            rsp_data <= '0;
            rsp_rd   <= '0;
            rsp_we   <= 1'b0;
            rsp_cout <= 1'b0;
            rsp_ovf  <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        if (dec_illegal) begin
                            rsp_data <= '0;
                            rsp_rd   <= rd_f;
                            rsp_we   <= 1'b0;
                            rsp_cout <= 1'b0;
                            rsp_ovf  <= 1'b0;
                            rsp_err  <= 1'b1;
                        end else begin
                            alu_a   <= dec_shift ? cmd_rt_data : cmd_rs_data;
                            alu_b   <= dec_shift ? {27'b0, shamt} : cmd_rt_data;
                            alu_sel <= dec_sel;
                            cnt_q   <= SETTLE_INIT;
                            rd_q    <= rd_f;
                            arith_q <= dec_arith;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        rsp_data <= alu_out;
                        rsp_rd   <= rd_q;
                        rsp_cout <= arith_q & alu_cout;
                        rsp_ovf  <= arith_q & alu_ovf;
                        rsp_we   <= (rd_q != 5'd0) && !ovf_trap;
                        rsp_err  <= ovf_trap;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu32_issue_ctrl.sv
// Directed self-checking bench for alu32_issue_ctrl with a behavioural alu32.
// Instance u_dut1 uses SETTLE_CYCLES=1, u_dut4 uses SETTLE_CYCLES=4.
module tb_alu32_issue_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural alu32: returns {ovf, cout, out}. Logic ops and shifts drive
    // cout/ovf high so the controller's forcing to 0 is observable.
    function automatic logic [33:0] alu_model(logic [31:0] a, logic [31:0] b, logic [2:0] s);
        logic [32:0]        r;
        logic               ov;
        logic signed [31:0] sa;
        logic [31:0]        t;
        sa = a;
        case (s)
            3'd0: return {2'b11, a & b};
            3'd1: return {2'b11, a | b};
            3'd2: begin
                r  = {1'b0, a} + {1'b0, b};
                ov = (a[31] == b[31]) && (r[31] != a[31]);
                return {ov, r[32], r[31:0]};
            end
            3'd3: return {2'b11, a ^ b};
            3'd4: begin
                r  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                ov = (a[31] != b[31]) && (r[31] != a[31]);
                return {ov, r[32], r[31:0]};
            end
            3'd5: begin
                t = sa >>> b[4:0];
                return {2'b11, t};
            end
            3'd6: return {2'b11, a << b[4:0]};
            default: return {2'b11, ~(a | b)};
        endcase
    endfunction

    function automatic logic [31:0] enc(logic [5:0] op, logic [4:0] rd, logic [4:0] sh, logic [5:0] fn);
        return {op, 5'd1, 5'd2, rd, sh, fn};
    endfunction

    // SETTLE_CYCLES = 1 instance
    logic        rst_n1, cmd_valid1, cmd_ready1, rsp_valid1, rsp_ready1;
    logic [31:0] cmd_instr1, cmd_rs1, cmd_rt1, alu_a1, alu_b1, alu_out1, rsp_data1;
    logic [2:0]  alu_sel1;
    logic        alu_cout1, alu_ovf1, rsp_we1, rsp_cout1, rsp_ovf1, rsp_err1;
    logic [4:0]  rsp_rd1;

    assign {alu_ovf1, alu_cout1, alu_out1} = alu_model(alu_a1, alu_b1, alu_sel1);

    alu32_issue_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_instr(cmd_instr1), .cmd_rs_data(cmd_rs1), .cmd_rt_data(cmd_rt1),
        .alu_a(alu_a1), .alu_b(alu_b1), .alu_sel(alu_sel1),
        .alu_out(alu_out1), .alu_cout(alu_cout1), .alu_ovf(alu_ovf1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_data(rsp_data1),
        .rsp_rd(rsp_rd1), .rsp_we(rsp_we1), .rsp_cout(rsp_cout1),
        .rsp_ovf(rsp_ovf1), .rsp_err(rsp_err1)
    );

    // SETTLE_CYCLES = 4 instance
    logic        rst_n4, cmd_valid4, cmd_ready4, rsp_valid4, rsp_ready4;
    logic [31:0] cmd_instr4, cmd_rs4, cmd_rt4, alu_a4, alu_b4, alu_out4, rsp_data4;
    logic [2:0]  alu_sel4;
    logic        alu_cout4, alu_ovf4, rsp_we4, rsp_cout4, rsp_ovf4, rsp_err4;
    logic [4:0]  rsp_rd4;

    assign {alu_ovf4, alu_cout4, alu_out4} = alu_model(alu_a4, alu_b4, alu_sel4);

    alu32_issue_ctrl #(.SETTLE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n4), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
        .cmd_instr(cmd_instr4), .cmd_rs_data(cmd_rs4), .cmd_rt_data(cmd_rt4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4),
        .alu_out(alu_out4), .alu_cout(alu_cout4), .alu_ovf(alu_ovf4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_data(rsp_data4),
        .rsp_rd(rsp_rd4), .rsp_we(rsp_we4), .rsp_cout(rsp_cout4),
        .rsp_ovf(rsp_ovf4), .rsp_err(rsp_err4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle command pulse on u_dut1; returns just after the accept edge
    task automatic issue1(input logic [31:0] instr, input logic [31:0] rs, input logic [31:0] rt);
        cmd_instr1 = instr;
        cmd_rs1    = rs;
        cmd_rt1    = rt;
        cmd_valid1 = 1'b1;
        step();
        cmd_valid1 = 1'b0;
    endtask

    // Response handshake on u_dut1
    task automatic ack1();
        rsp_ready1 = 1'b1;
        step();
        rsp_ready1 = 1'b0;
    endtask

    int cyc;

    initial begin
        rst_n1 = 1'b0; cmd_valid1 = 1'b0; rsp_ready1 = 1'b0;
        cmd_instr1 = '0; cmd_rs1 = '0; cmd_rt1 = '0;
        rst_n4 = 1'b0; cmd_valid4 = 1'b0; rsp_ready4 = 1'b0;
        cmd_instr4 = '0; cmd_rs4 = '0; cmd_rt4 = '0;

        // Reset state
        step();
        step();
        chk("rst_cmd_ready", 32'(cmd_ready1), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        chk("rst_alu_a", alu_a1, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err1), 32'd0);
        rst_n1 = 1'b1;
        rst_n4 = 1'b1;
        #1;
        chk("rel_cmd_ready", 32'(cmd_ready1), 32'd1);
        step();

        // ADD with carry, no overflow
        issue1(enc(6'h00, 5'd8, 5'd0, 6'h20), 32'hC00000EA, 32'hF1E00000);
        chk("add_sel", 32'(alu_sel1), 32'd2);
        chk("add_alu_a", alu_a1, 32'hC00000EA);
        chk("add_alu_b", alu_b1, 32'hF1E00000);
        chk("add_valid_early", 32'(rsp_valid1), 32'd0);
        chk("add_cmd_ready_busy", 32'(cmd_ready1), 32'd0);
        step();
        chk("add_valid", 32'(rsp_valid1), 32'd1);
        chk("add_data", rsp_data1, 32'hB1E000EA);
        chk("add_cout", 32'(rsp_cout1), 32'd1);
        chk("add_ovf", 32'(rsp_ovf1), 32'd0);
        chk("add_we", 32'(rsp_we1), 32'd1);
        chk("add_rd", 32'(rsp_rd1), 32'd8);
        chk("add_err", 32'(rsp_err1), 32'd0);
        ack1();
        chk("add_done_valid", 32'(rsp_valid1), 32'd0);
        chk("add_done_ready", 32'(cmd_ready1), 32'd1);

        // SUB with signed overflow
        issue1(enc(6'h00, 5'd9, 5'd0, 6'h22), 32'h7FFFFFFF, 32'hFFFFFFFF);
        chk("sub_sel", 32'(alu_sel1), 32'd4);
        step();
        chk("sub_valid", 32'(rsp_valid1), 32'd1);
        chk("sub_data", rsp_data1, 32'h80000000);
        chk("sub_ovf", 32'(rsp_ovf1), 32'd1);
`ifdef ALU_OVF_TRAP_EN
        chk("sub_err", 32'(rsp_err1), 32'd1);
        chk("sub_we", 32'(rsp_we1), 32'd0);
`else
        chk("sub_err", 32'(rsp_err1), 32'd0);
        chk("sub_we", 32'(rsp_we1), 32'd1);
`endif
        ack1();

        // SRA: operand A from rt, B is shamt
        issue1(enc(6'h00, 5'd10, 5'd3, 6'h03), 32'h12345678, 32'hC00000FF);
        chk("sra_sel", 32'(alu_sel1), 32'd5);
        chk("sra_alu_a", alu_a1, 32'hC00000FF);
        chk("sra_alu_b", alu_b1, 32'd3);
        step();
        chk("sra_data", rsp_data1, 32'hF800001F);
        chk("sra_cout", 32'(rsp_cout1), 32'd0);
        chk("sra_ovf", 32'(rsp_ovf1), 32'd0);
        chk("sra_rd", 32'(rsp_rd1), 32'd10);
        ack1();

        // SLL
        issue1(enc(6'h00, 5'd11, 5'd3, 6'h00), 32'h12345678, 32'hC00000FF);
        chk("sll_sel", 32'(alu_sel1), 32'd6);
        chk("sll_alu_b", alu_b1, 32'd3);
        step();
        chk("sll_data", rsp_data1, 32'h000007F8);
        chk("sll_cout", 32'(rsp_cout1), 32'd0);
        chk("sll_ovf", 32'(rsp_ovf1), 32'd0);
        ack1();

        // Illegal funct: response on the cycle after accept, ALU regs untouched
        issue1(enc(6'h00, 5'd12, 5'd0, 6'h2A), 32'h11111111, 32'h22222222);
        chk("ill_valid", 32'(rsp_valid1), 32'd1);
        chk("ill_err", 32'(rsp_err1), 32'd1);
        chk("ill_we", 32'(rsp_we1), 32'd0);
        chk("ill_data", rsp_data1, 32'd0);
        chk("ill_rd", 32'(rsp_rd1), 32'd12);
        chk("ill_alu_sel_hold", 32'(alu_sel1), 32'd6);
        ack1();

        // Illegal opcode with otherwise valid funct
        issue1(enc(6'h08, 5'd13, 5'd0, 6'h20), 32'd1, 32'd2);
        chk("op_valid", 32'(rsp_valid1), 32'd1);
        chk("op_err", 32'(rsp_err1), 32'd1);
        chk("op_we", 32'(rsp_we1), 32'd0);
        ack1();

        // Backpressure: AND response held 5 cycles while a second command waits
        issue1(enc(6'h00, 5'd5, 5'd0, 6'h24), 32'hF0F0F0F0, 32'hFF00FF00);
        step();
        cmd_instr1 = enc(6'h00, 5'd6, 5'd0, 6'h25);
        cmd_rs1    = 32'h0000000F;
        cmd_rt1    = 32'h000000F0;
        cmd_valid1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_cmd_ready", 32'(cmd_ready1), 32'd0);
            chk("bp_data", rsp_data1, 32'hF000F000);
            chk("bp_valid", 32'(rsp_valid1), 32'd1);
            step();
        end
        chk("bp_rd", 32'(rsp_rd1), 32'd5);
        chk("bp_cout", 32'(rsp_cout1), 32'd0);
        chk("bp_alu_a_hold", alu_a1, 32'hF0F0F0F0);
        rsp_ready1 = 1'b1;
        step();
        rsp_ready1 = 1'b0;
        chk("bp_idle_ready", 32'(cmd_ready1), 32'd1);
        chk("bp_idle_valid", 32'(rsp_valid1), 32'd0);
        step();
        cmd_valid1 = 1'b0;
        chk("bp2_sel", 32'(alu_sel1), 32'd1);
        chk("bp2_alu_a", alu_a1, 32'h0000000F);
        step();
        chk("bp2_valid", 32'(rsp_valid1), 32'd1);
        chk("bp2_data", rsp_data1, 32'h000000FF);
        chk("bp2_rd", 32'(rsp_rd1), 32'd6);
        ack1();

        // SETTLE_CYCLES=4: reset in the middle of WAIT
        cmd_instr4 = enc(6'h00, 5'd7, 5'd0, 6'h20);
        cmd_rs4    = 32'd5;
        cmd_rt4    = 32'd6;
        cmd_valid4 = 1'b1;
        step();
        cmd_valid4 = 1'b0;
        chk("w4_alu_a", alu_a4, 32'd5);
        step();
        rst_n4 = 1'b0;
        step();
        chk("w4_rst_valid", 32'(rsp_valid4), 32'd0);
        chk("w4_rst_alu_a", alu_a4, 32'd0);
        chk("w4_rst_alu_b", alu_b4, 32'd0);
        chk("w4_rst_sel", 32'(alu_sel4), 32'd0);
        chk("w4_rst_data", rsp_data4, 32'd0);
        chk("w4_rst_ready", 32'(cmd_ready4), 32'd0);
        rst_n4 = 1'b1;
        #1;
        chk("w4_rel_ready", 32'(cmd_ready4), 32'd1);
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid4) cyc++;
        end
        chk("w4_no_rsp", 32'(cyc), 32'd0);

        // AND to rd=0 on the settle-4 instance: data reported, no write
        cmd_instr4 = enc(6'h00, 5'd0, 5'd0, 6'h24);
        cmd_rs4    = 32'hFFFF0000;
        cmd_rt4    = 32'h12345678;
        cmd_valid4 = 1'b1;
        step();
        cmd_valid4 = 1'b0;
        cyc = 0;
        while (!rsp_valid4 && cyc < 20) begin
            step();
            cyc++;
        end
        chk("w4_latency", 32'(cyc), 32'd4);
        chk("w4_data", rsp_data4, 32'h12340000);
        chk("w4_we", 32'(rsp_we4), 32'd0);
        chk("w4_err", 32'(rsp_err4), 32'd0);
        chk("w4_rd", 32'(rsp_rd4), 32'd0);
        rsp_ready4 = 1'b1;
        step();
        rsp_ready4 = 1'b0;
        chk("w4_done_ready", 32'(cmd_ready4), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
